// File: rtl/comparator_wide_serial.sv
// ---------------------------------------------------------------------------
// comparator_wide_serial
//
// Byte-serial unsigned magnitude comparator for wide operands. A start request
// latches both operands and the cascade triple {l,e,g}. The operands are then
// compared one byte per clock, starting with the most significant byte. The
// compare stops at the first unequal byte. If every byte is equal, the latched
// cascade triple is passed through unmodified. This matches the behaviour of
// the 8-bit comparator stage that sits downstream.
//
// Parameters
//   NBYTES  operand width in bytes (>=1), W = 8*NBYTES
//   IDXW    width of the byte index counter, 2**IDXW >= NBYTES
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  compare request, accepted only in IDLE or DONE
//   A, B   unsigned operands, sampled together with start
//   l/e/g  cascade less/equal/greater, sampled together with start
//   busy   high while the compare is in progress
//   done   one-cycle pulse; lt/et/gt are valid from this cycle on
//   lt     A < B
//   et     A == B, qualified by the cascade input
//   gt     A > B
// ---------------------------------------------------------------------------
module comparator_wide_serial #(
  parameter int NBYTES = 4,
  parameter int IDXW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  l,
  input  logic                  e,
  input  logic                  g,
  output logic                  busy,
  output logic                  done,
  output logic                  lt,
  output logic                  et,
  output logic                  gt
);

  localparam int W = 8 * NBYTES;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [2:0]      casc;
  logic [IDXW-1:0] idx;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;

  // The operand copies are shifted left after each equal byte. Because of
  // this, the byte under test is always the top byte, and no variable-index
  // mux is needed.
  assign a_byte = a_sh[W-1 -: 8];
  assign b_byte = b_sh[W-1 -: 8];

  // The FSM and all outputs are registered. done is set only on the
  // transition into DONE. A reset abandons any compare in flight without
  // producing a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      casc  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      et    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh          <= A;
            b_sh          <= B;
            casc          <= {l, e, g};
            idx           <= '0;
            {lt, et, gt}  <= 3'b000;
            busy          <= 1'b1;
            state         <= CMP;
          end else begin
            // Results are held here until the next accepted start.
            state <= IDLE;
          end
        end

        CMP: begin
          if (a_byte > b_byte) begin
            {lt, et, gt} <= 3'b001;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else if (a_byte < b_byte) begin
            {lt, et, gt} <= 3'b100;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else if (idx == LAST_IDX) begin
            // All bytes are equal, so the cascade triple decides the result.
            // Illegal triples are passed through unmodified.
            {lt, et, gt} <= casc;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            idx  <= idx + 1'b1;
            a_sh <= a_sh << 8;
            b_sh <= b_sh << 8;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_wide_serial.sv
// ---------------------------------------------------------------------------
// tb_comparator_wide_serial
//
// Testbench for comparator_wide_serial with NBYTES=4.
//
// The stimulus side pushes the expected result into a scoreboard queue, along
// with the cycle on which done must appear. The expected values come from
// whole-word unsigned arithmetic and the position of the first differing byte.
// A separate monitor pops one entry for every done pulse and compares it.
// ---------------------------------------------------------------------------
module tb_comparator_wide_serial;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         l = 1'b0;
  logic         e = 1'b0;
  logic         g = 1'b0;
  logic         busy;
  logic         done;
  logic         lt;
  logic         et;
  logic         gt;

  typedef struct {
    logic [2:0] res;
    int         done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  comparator_wide_serial #(.NBYTES(NB), .IDXW(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .l     (l),
    .e     (e),
    .g     (g),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .et    (et),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model. The result comes from whole-word unsigned comparison.
  // The latency is the 1-based position, counted from the MSB, of the first
  // differing byte. It is NB when all bytes are equal.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] c, input int t0);
    exp_t r;
    int   lat;
    lat = NB;
    for (int k = 0; k < NB; k++) begin
      if (((a >> (8 * (NB - 1 - k))) & 32'hFF) != ((b >> (8 * (NB - 1 - k))) & 32'hFF)) begin
        lat = k + 1;
        break;
      end
    end
    if (a > b)      r.res = 3'b001;
    else if (a < b) r.res = 3'b100;
    else            r.res = c;
    r.done_cyc = t0 + lat;
    return r;
  endfunction

  // The monitor runs on the falling edge. Each done pulse must match the
  // entry at the head of the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 at cyc %0d, required no done", cyc);
      end else begin
        x = sbq.pop_front();
        total++;
        if ({lt, et, gt} !== x.res) begin
          bad++;
          $display("[TB] FAIL result: got %b required %b", {lt, et, gt}, x.res);
        end
        total++;
        if (cyc != x.done_cyc) begin
          bad++;
          $display("[TB] FAIL latency: done at cyc %0d required cyc %0d", cyc, x.done_cyc);
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL busy_at_done: got %b required 0", busy);
        end
      end
    end
  end

  // Issues one compare. start is sampled at edge T0. After T0 the operands
  // are scrambled, and this must not affect the compare in flight.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] c);
    @(negedge clk);
    A = a;
    B = b;
    {l, e, g} = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back(model(a, b, c, cyc));
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    {l, e, g} = 3'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] exp_v);
    total++;
    if ({busy, done, lt, et, gt} !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got {busy,done,lt,et,gt}=%b required %b",
               name, {busy, done, lt, et, gt}, exp_v);
    end
  endtask

  // Waits, with a cycle bound, until the scoreboard has been drained.
  task automatic waitIdle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout_%s: %0d results outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [7:0]   x;
    int           k;
    bit           got_done;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    // MSB byte differs: done after 1 cycle.
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 3'b010);
    waitIdle("t1");
    @(negedge clk);
    checkOutput("t1_hold", 5'b00001);

    // LSB byte differs: done after the full 4 cycles.
    applyStimulus(32'h1234_5678, 32'h1234_5679, 3'b010);
    waitIdle("t2");
    @(negedge clk);
    checkOutput("t2_hold", 5'b00100);

    // All bytes equal: the cascade triple passes through.
    applyStimulus(32'hCBCB_CBCB, 32'hCBCB_CBCB, 3'b010);
    waitIdle("t3a");
    applyStimulus(32'hCBCB_CBCB, 32'hCBCB_CBCB, 3'b100);
    waitIdle("t3b");
    @(negedge clk);
    checkOutput("t3_hold", 5'b00100);

    // An illegal cascade triple also passes through unmodified.
    applyStimulus(32'h0000_0001, 32'h0000_0001, 3'b110);
    waitIdle("t3c");

    // A second start while busy is ignored.
    applyStimulus(32'h0, 32'h0, 3'b010);
    @(negedge clk);
    A = 32'hFF00_0000;
    B = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_busy", 5'b10000);
    start = 1'b0;
    waitIdle("t4");
    repeat (4) @(negedge clk);
    checkOutput("t4_hold", 5'b00010);

    // Reset mid-compare: the compare is abandoned and no done appears.
    applyStimulus(32'hABCD_EF01, 32'hABCD_EF01, 3'b001);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    checkOutput("t5_reset", 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5_idle", 5'b00000);
    applyStimulus(32'h0000_1000, 32'h0000_2000, 3'b010);
    waitIdle("t5_after");

    // Back-to-back: start is held high through DONE, so the second compare
    // starts at the DONE edge without an IDLE cycle in between.
    @(negedge clk);
    A = 32'h5555_0000;
    B = 32'h5555_FFFF;
    {l, e, g} = 3'b010;
    start = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back(model(32'h5555_0000, 32'h5555_FFFF, 3'b010, cyc));
    A = 32'h0F0F_0F0F;
    B = 32'h0F0F_0F0F;
    {l, e, g} = 3'b001;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) begin
      total++;
      bad++;
      $display("[TB] FAIL t6_first_done: got no done, required done within 20 cycles");
    end
    sbq.push_back(model(32'h0F0F_0F0F, 32'h0F0F_0F0F, 3'b001, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("t6_rearm", 5'b10000);
    waitIdle("t6");
    repeat (3) @(negedge clk);
    checkOutput("t6_hold", 5'b00001);

    // Random compares. Most operand pairs share a prefix, so the first
    // differing byte varies.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = ra;
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, NB - 1);
        x = 8'($urandom_range(1, 255));
        rb = ra ^ ({24'b0, x} << (8 * (NB - 1 - k)));
        if ($urandom_range(0, 1) == 1)
          rb = rb ^ (W'($urandom) & ((32'h1 << (8 * (NB - 1 - k))) - 1));
      end
      applyStimulus(ra, rb, 3'($urandom));
      waitIdle("rand");
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
